// File: rtl/trap_controller.sv
// Machine-mode trap controller: latches local interrupt edges, applies
// per-source and global enables, picks one interrupt or exception by fixed
// priority, and holds it as a registered trap request until the pipeline
// acknowledges it. Tracks handler entry (ack) and exit (MRET) for MIE/MPIE.
//
// Handshake o_TrapValid / i_TrapAck: o_TrapValid high means a request is
// offered, and o_Interrupt / o_ExceptionCause stay stable while it is high.
// The request transfers on a cycle where o_TrapValid and i_TrapAck are both
// high. o_TrapValid drops after that edge. i_TrapAck while o_TrapValid is low
// is ignored.
//
// o_DebugState exposes the FSM: 0 = IDLE, 1 = REQUEST, 2 = HANDLER.
module trap_controller #(
  parameter int NUM_LOCAL_IRQ = 4,
  parameter int CAUSE_WIDTH   = 5
) (
  input  logic                     i_Clock,
  input  logic                     i_Reset_n,
  input  logic                     i_ExternalInterrupt,
  input  logic                     i_SoftwareInterrupt,
  input  logic                     i_TimerInterrupt,
  input  logic [NUM_LOCAL_IRQ-1:0] i_LocalInterrupt,
  input  logic                     i_InstructionAccessFault,
  input  logic                     i_IllegalInstruction,
  input  logic                     i_InstructionAddressMisaligned,
  input  logic                     i_EnvironmentCall,
  input  logic                     i_EnvironmentBreak,
  input  logic                     i_LoadAddressMisaligned,
  input  logic                     i_LoadAccessFault,
  input  logic                     i_MieWrite,
  input  logic [NUM_LOCAL_IRQ+2:0] i_MieWriteValue,
  input  logic                     i_MstatusMieWrite,
  input  logic                     i_MstatusMieValue,
  input  logic                     i_TrapAck,
  input  logic                     i_Mret,
  output logic                     o_TrapValid,
  output logic                     o_Interrupt,
  output logic [CAUSE_WIDTH-1:0]   o_ExceptionCause,
  output logic                     o_Mie,
  output logic                     o_Mpie,
  output logic [NUM_LOCAL_IRQ-1:0] o_LocalPending,
  output logic [1:0]               o_DebugState
);

  localparam int MIE_WIDTH = NUM_LOCAL_IRQ + 3;
  // Internal cause is at least 5 bits so local causes (16+k) are representable.
  localparam int INT_CW    = (CAUSE_WIDTH > 5) ? CAUSE_WIDTH : 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    HANDLER = 2'd2
  } trapState_e;

  trapState_e               state;
  trapState_e               nextState;

  logic [NUM_LOCAL_IRQ-1:0] localPrev;
  logic [NUM_LOCAL_IRQ-1:0] localPending;
  logic [NUM_LOCAL_IRQ-1:0] localRise;
  logic [NUM_LOCAL_IRQ-1:0] localClear;
  logic [NUM_LOCAL_IRQ-1:0] localEligible;
  logic [NUM_LOCAL_IRQ-1:0] winLocal;
  logic [NUM_LOCAL_IRQ-1:0] trapLocal;
  logic [MIE_WIDTH-1:0]     mieReg;
  logic                     mstatusMie;
  logic                     mstatusMpie;
  logic                     extEligible;
  logic                     swEligible;
  logic                     timerEligible;
  logic [INT_CW-1:0]        winCause;
  logic                     winInterrupt;
  logic                     eventAny;
  logic [CAUSE_WIDTH-1:0]   causeReg;
  logic                     interruptReg;
  logic                     loadTrap;
  logic                     ackTake;
  logic                     mretTake;

  assign localRise     = i_LocalInterrupt & ~localPrev;
  assign localEligible = localPending & mieReg[MIE_WIDTH-1:3] & {NUM_LOCAL_IRQ{mstatusMie}};
  assign extEligible   = i_ExternalInterrupt & mieReg[0] & mstatusMie;
  assign swEligible    = i_SoftwareInterrupt & mieReg[1] & mstatusMie;
  assign timerEligible = i_TimerInterrupt    & mieReg[2] & mstatusMie;
  // Only the local line that was actually taken is cleared on acknowledge.
  assign localClear    = ackTake ? trapLocal : '0;

  // Fixed-priority pick: any eligible interrupt beats every exception.
  always_comb begin
    winCause     = '0;
    winInterrupt = 1'b0;
    winLocal     = '0;
    eventAny     = 1'b1;
    if (extEligible) begin
      winCause     = INT_CW'(11);
      winInterrupt = 1'b1;
    end else if (swEligible) begin
      winCause     = INT_CW'(3);
      winInterrupt = 1'b1;
    end else if (timerEligible) begin
      winCause     = INT_CW'(7);
      winInterrupt = 1'b1;
    end else if (|localEligible) begin
      winInterrupt = 1'b1;
      // Scan downward so the lowest-numbered eligible line is the last hit.
      for (int k = NUM_LOCAL_IRQ - 1; k >= 0; k--) begin
        if (localEligible[k]) begin
          winLocal    = '0;
          winLocal[k] = 1'b1;
          winCause    = INT_CW'(16 + k);
        end
      end
    end else if (i_InstructionAccessFault) begin
      winCause = INT_CW'(1);
    end else if (i_IllegalInstruction) begin
      winCause = INT_CW'(2);
    end else if (i_InstructionAddressMisaligned) begin
      winCause = INT_CW'(0);
    end else if (i_EnvironmentCall) begin
      winCause = INT_CW'(11);
    end else if (i_EnvironmentBreak) begin
      winCause = INT_CW'(3);
    end else if (i_LoadAddressMisaligned) begin
      winCause = INT_CW'(4);
    end else if (i_LoadAccessFault) begin
      winCause = INT_CW'(5);
    end else begin
      eventAny = 1'b0;
    end
  end

  // Next-state logic; in HANDLER an MRET takes precedence over a new event.
  always_comb begin
    nextState = state;
    loadTrap  = 1'b0;
    ackTake   = 1'b0;
    mretTake  = 1'b0;
    case (state)
      IDLE: begin
        mretTake = i_Mret;
        if (eventAny) begin
          nextState = REQUEST;
          loadTrap  = 1'b1;
        end
      end
      REQUEST: begin
        if (i_TrapAck) begin
          ackTake   = 1'b1;
          nextState = HANDLER;
        end
      end
      HANDLER: begin
        if (i_Mret) begin
          mretTake  = 1'b1;
          nextState = IDLE;
        end else if (eventAny) begin
          nextState = REQUEST;
          loadTrap  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // FSM state and latched trap payload (frozen while in REQUEST).
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state        <= IDLE;
      causeReg     <= '0;
      interruptReg <= 1'b0;
      trapLocal    <= '0;
    end else begin
      state <= nextState;
      if (loadTrap) begin
        causeReg     <= winCause[CAUSE_WIDTH-1:0];
        interruptReg <= winInterrupt;
        trapLocal    <= winLocal;
      end
    end
  end

  // Local edge detect and pending bits; a new edge wins over an ack clear.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      localPrev    <= '0;
      localPending <= '0;
    end else begin
      localPrev    <= i_LocalInterrupt;
      localPending <= (localPending & ~localClear) | localRise;
    end
  end

  // Per-source enable register.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      mieReg <= '0;
    end else if (i_MieWrite) begin
      mieReg <= i_MieWriteValue;
    end
  end

  // Global enable stack: ack beats MRET beats a direct CSR write.
  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      mstatusMie  <= 1'b0;
      mstatusMpie <= 1'b0;
    end else if (ackTake) begin
      mstatusMpie <= mstatusMie;
      mstatusMie  <= 1'b0;
    end else if (mretTake) begin
      mstatusMie  <= mstatusMpie;
      mstatusMpie <= 1'b1;
    end else if (i_MstatusMieWrite) begin
      mstatusMie  <= i_MstatusMieValue;
    end
  end

  assign o_TrapValid      = (state == REQUEST);
  assign o_Interrupt      = interruptReg;
  assign o_ExceptionCause = causeReg;
  assign o_Mie            = mstatusMie;
  assign o_Mpie           = mstatusMpie;
  assign o_LocalPending   = localPending;
  assign o_DebugState     = state;

endmodule
